// File: rtl/dist_ram_pkg.sv
// Shared types and mode constants for the dual-port distributed RAM.
package dist_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

  localparam int READ_ASYNC      = 0;
  localparam int READ_SYNC       = 1;
  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

endpackage

// File: rtl/dist_ram_clr_fsm.sv
// Clear sequencer: walks every address once after reset or on clr_req,
// and flags user writes that arrive while the array is being cleared.
module dist_ram_clr_fsm
  import dist_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  clr_req,
  input  logic                  we,
  output logic                  busy,
  output logic                  wr_drop,
  output logic [ADDR_WIDTH-1:0] ptr
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  busy_q, busy_d;
  logic                  wr_drop_q, wr_drop_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    wr_drop_d = we && busy_q;
    case (state_q)
      CLEAR: begin
        // Pointer wraps to 0 naturally after the last address.
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (&ptr_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        busy_d  = 1'b1;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      busy_q    <= 1'b1;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;
  assign ptr     = ptr_q;

endmodule

// File: rtl/dist_ram_dp.sv
// Dual-port distributed RAM: port A read/write with byte lanes, port B read-only,
// async or registered read, with a clear sequencer owning the write port while busy.
module dist_ram_dp
  import dist_ram_pkg::*;
#(
  parameter int                  DATA_WIDTH = 16,
  parameter int                  ADDR_WIDTH = 6,
  parameter int                  BYTE_WIDTH = 8,
  parameter int                  READ_MODE  = 0,
  parameter int                  RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             RST,
  input  logic                             clr_req,
  output logic                             busy,
  output logic                             wr_drop,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  input  logic [ADDR_WIDTH-1:0]            a,
  input  logic [DATA_WIDTH-1:0]            di,
  input  logic                             re_a,
  output logic [DATA_WIDTH-1:0]            spo,
  input  logic [ADDR_WIDTH-1:0]            dpra,
  input  logic                             re_b,
  output logic [DATA_WIDTH-1:0]            dpo
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [NB-1:0]         en);
    merge_lanes = old_w;
    for (int i = 0; i < NB; i++) begin
      if (en[i]) merge_lanes[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  user_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] rd_a, rd_b, new_a, coll_a;

  dist_ram_clr_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clr_fsm (
    .clk     (clk),
    .RST     (RST),
    .clr_req (clr_req),
    .we      (we),
    .busy    (busy),
    .wr_drop (wr_drop),
    .ptr     (clr_addr)
  );

  // The clear sequencer owns the single write port for the whole pass.
  always_comb begin
    user_we = we && !busy;
    if (busy) begin
      wr_addr = clr_addr;
      wr_data = INIT_VALUE;
      wr_be   = '1;
    end else begin
      wr_addr = a;
      wr_data = di;
      wr_be   = user_we ? be : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) mem_q[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign rd_a   = busy ? INIT_VALUE : mem_q[a];
  assign rd_b   = busy ? INIT_VALUE : mem_q[dpra];
  assign new_a  = merge_lanes(mem_q[a], di, be);
  assign coll_a = (RDW_MODE != RDW_READ_FIRST && user_we) ? new_a : rd_a;

  if (READ_MODE == READ_SYNC) begin : g_sync
    logic [DATA_WIDTH-1:0] spo_q, spo_d, dpo_q, dpo_d;

    always_comb begin
      spo_d = re_a ? coll_a : spo_q;
      dpo_d = re_b ? rd_b : dpo_q;
    end

    always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
        spo_q <= '0;
        dpo_q <= '0;
      end else begin
        spo_q <= spo_d;
        dpo_q <= dpo_d;
      end
    end

    assign spo = spo_q;
    assign dpo = dpo_q;
  end else begin : g_async
    // Read enables and the collision path only matter in registered mode.
    logic unused_rd;
    assign unused_rd = ^{re_a, re_b, coll_a};
    assign spo = rd_a;
    assign dpo = rd_b;
  end

endmodule

// File: tb/tb_dist_ram_dp.sv
// Self-checking bench: async (INIT 0000) and registered write-first / read-first
// (INIT FFFF) instances share stimulus and are compared with a behavioural model.
module tb_dist_ram_dp;

  logic        clk = 1'b0;
  logic        RST;
  logic        clr_req, we, re_a, re_b;
  logic [1:0]  be;
  logic [5:0]  a, dpra;
  logic [15:0] di;

  logic        busy_as, busy_wf, busy_rf, drop_as, drop_wf, drop_rf;
  logic [15:0] spo_as, dpo_as, spo_wf, dpo_wf, spo_rf, dpo_rf;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [15:0] m0 [64];
  logic [15:0] m1 [64];
  bit          mbusy;
  int          mptr;
  bit          mdrop;
  logic [15:0] e_spo_wf, e_spo_rf, e_dpo_s;

  always #5 clk = ~clk;

  dist_ram_dp #(.READ_MODE(0), .RDW_MODE(0), .INIT_VALUE(16'h0000)) u_as (
    .clk(clk), .RST(RST), .clr_req(clr_req), .busy(busy_as), .wr_drop(drop_as),
    .we(we), .be(be), .a(a), .di(di), .re_a(re_a), .spo(spo_as),
    .dpra(dpra), .re_b(re_b), .dpo(dpo_as));

  dist_ram_dp #(.READ_MODE(1), .RDW_MODE(0), .INIT_VALUE(16'hFFFF)) u_wf (
    .clk(clk), .RST(RST), .clr_req(clr_req), .busy(busy_wf), .wr_drop(drop_wf),
    .we(we), .be(be), .a(a), .di(di), .re_a(re_a), .spo(spo_wf),
    .dpra(dpra), .re_b(re_b), .dpo(dpo_wf));

  dist_ram_dp #(.READ_MODE(1), .RDW_MODE(1), .INIT_VALUE(16'hFFFF)) u_rf (
    .clk(clk), .RST(RST), .clr_req(clr_req), .busy(busy_rf), .wr_drop(drop_rf),
    .we(we), .be(be), .a(a), .di(di), .re_a(re_a), .spo(spo_rf),
    .dpra(dpra), .re_b(re_b), .dpo(dpo_rf));

  function automatic logic [15:0] lanes(logic [15:0] o, logic [15:0] n, logic [1:0] e);
    lanes = o;
    if (e[0]) lanes[7:0] = n[7:0];
    if (e[1]) lanes[15:8] = n[15:8];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy_as", 16'(busy_as), 16'(mbusy));
    chk("busy_wf", 16'(busy_wf), 16'(mbusy));
    chk("busy_rf", 16'(busy_rf), 16'(mbusy));
    chk("drop_as", 16'(drop_as), 16'(mdrop));
    chk("drop_rf", 16'(drop_rf), 16'(mdrop));
    chk("spo_as", spo_as, mbusy ? 16'h0000 : m0[a]);
    chk("dpo_as", dpo_as, mbusy ? 16'h0000 : m0[dpra]);
    chk("spo_wf", spo_wf, e_spo_wf);
    chk("spo_rf", spo_rf, e_spo_rf);
    chk("dpo_wf", dpo_wf, e_dpo_s);
    chk("dpo_rf", dpo_rf, e_dpo_s);
  endtask

  // One clock edge: apply the memory rules to the model, then compare.
  task automatic step();
    logic [15:0] old1, new1;
    @(posedge clk);
    if (RST) begin
      old1 = m1[a];
      new1 = lanes(old1, di, be);
      if (re_a) begin
        e_spo_wf = mbusy ? 16'hFFFF : (we ? new1 : old1);
        e_spo_rf = mbusy ? 16'hFFFF : old1;
      end
      if (re_b) e_dpo_s = mbusy ? 16'hFFFF : m1[dpra];
      mdrop = mbusy && we;
      if (mbusy) begin
        m0[mptr] = 16'h0000;
        m1[mptr] = 16'hFFFF;
        mptr++;
        if (mptr == 64) begin
          mbusy = 1'b0;
          mptr  = 0;
        end
      end else begin
        if (we) begin
          m0[a] = lanes(m0[a], di, be);
          m1[a] = new1;
        end
        if (clr_req) begin
          mbusy = 1'b1;
          mptr  = 0;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic assert_reset();
    RST      = 1'b0;
    mbusy    = 1'b1;
    mptr     = 0;
    mdrop    = 1'b0;
    e_spo_wf = '0;
    e_spo_rf = '0;
    e_dpo_s  = '0;
    #1;
    check_all();
  endtask

  task automatic quiet();
    clr_req = 0; we = 0; be = 0; re_a = 0; re_b = 0;
  endtask

  task automatic rand_inputs(input bit allow_clr);
    we      = 1'($urandom);
    be      = 2'($urandom);
    a       = 6'($urandom);
    dpra    = 6'($urandom);
    di      = 16'($urandom);
    re_a    = 1'($urandom);
    re_b    = 1'($urandom);
    clr_req = allow_clr && ($urandom_range(0, 39) == 0);
  endtask

  // Mode 0: quiet, 1: random traffic, 2: we at cycle 10 and a stray clr_req at cycle 20.
  task automatic count_busy(input int mode, output int hi, output int drops);
    hi = 0;
    drops = 0;
    for (int c = 0; c < 200 && busy_as; c++) begin
      if (mode == 1) rand_inputs(1'b1);
      if (mode == 2) begin
        we = (hi == 10); be = 2'b11; a = 6'd7; di = 16'h1234;
        clr_req = (hi == 20);
      end
      hi++;
      step();
      if (drop_as) drops++;
    end
    n_cmp++;
    assert (!busy_as) else begin
      n_err++;
      $error("FAIL busy_timeout observed=%0d expected=0", busy_as);
    end
    quiet();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, drops;
    RST = 1'b1;
    quiet();
    a = 0; dpra = 0; di = 0;
    mptr = 0;
    #2;
    assert_reset();
    step();
    step();
    #2 RST = 1'b1;

    // First pass after reset release, with random traffic that must be dropped
    count_busy(1, hi, drops);
    chk("pass0_len", 16'(hi), 16'd64);

    for (int i = 0; i < 64; i++) begin
      a = 6'(i); dpra = 6'(i); re_a = 1; re_b = 1;
      step();
    end
    quiet();

    // Byte-lane writes
    a = 6'd5; we = 1; be = 2'b01; di = 16'hABCD; step();
    chk("lane_lo", spo_as, 16'h00CD);
    be = 2'b10; di = 16'h12FF; step();
    we = 0; dpra = 6'd5; re_b = 1; step();
    chk("lane_hi_as", dpo_as, 16'h12CD);
    chk("lane_hi_wf", dpo_wf, 16'h12CD);
    quiet();

    // Port A collision in registered mode
    a = 6'd3; we = 1; be = 2'b11; di = 16'h1111; step();
    di = 16'h2222; re_a = 1; dpra = 6'd3; re_b = 1; step();
    chk("coll_wf", spo_wf, 16'h2222);
    chk("coll_rf", spo_rf, 16'h1111);
    chk("coll_dpo", dpo_wf, 16'h1111);
    quiet();

    // Requested clear pass with a dropped write and an ignored clr_req
    clr_req = 1; step(); clr_req = 0;
    count_busy(2, hi, drops);
    chk("pass1_len", 16'(hi), 16'd64);
    chk("pass1_drops", 16'(drops), 16'd1);
    a = 6'd7; re_a = 1; step();
    chk("cleared_wf", spo_wf, 16'hFFFF);
    chk("cleared_as", spo_as, 16'h0000);
    quiet();

    // Reset in the middle of a pass
    clr_req = 1; step(); clr_req = 0;
    repeat (30) step();
    #2;
    assert_reset();
    step();
    #2 RST = 1'b1;
    count_busy(0, hi, drops);
    chk("pass2_len", 16'(hi), 16'd64);

    // Async read-after-write and address wrap
    a = 6'd63; we = 1; be = 2'b11; di = 16'hBEEF; step();
    we = 0; dpra = 6'd63; #1;
    chk("wrap_63", dpo_as, 16'hBEEF);
    a = 6'd0; we = 1; di = 16'hCAFE; step();
    we = 0; dpra = 6'd0; #1;
    chk("wrap_0", dpo_as, 16'hCAFE);
    dpra = 6'd63; #1;
    chk("wrap_63b", dpo_as, 16'hBEEF);

    // Random traffic including occasional clear requests
    for (int i = 0; i < 400; i++) begin
      rand_inputs(1'b1);
      step();
    end
    quiet();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dist_ram_dp.md
# dist_ram_dp

Parametrised dual-port distributed RAM: one read/write port (A) and one read-only port (B), with configurable width and depth, byte-lane write enables, selectable asynchronous or registered read, and a built-in clear sequencer that fills the array with a constant after reset or on request. It is the general-purpose small-buffer memory for line buffers, coefficient tables and FIFO storage in the hardware library.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- READ_MODE, 0, 0 = asynchronous read, 1 = registered read (1-cycle latency).
- RDW_MODE, 0, port A collision in registered mode: 0 = write-first, 1 = read-first.
- INIT_VALUE, 0, word written to every location by the clear sequencer.
- clk  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- clr_req  in  1  single-cycle request to start a clear pass.
- busy  out  1  high while a clear pass is running.
- wr_drop  out  1  one-cycle pulse: a write was rejected because busy was high.
- we  in  1  port A write enable.
- be  in  NB  port A byte-lane enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- a  in  ADDR_WIDTH  port A address.
- di  in  DATA_WIDTH  port A write data.
- re_a  in  1  port A read enable (registered mode only; ignored when async).
- spo  out  DATA_WIDTH  port A read data.
- dpra  in  ADDR_WIDTH  port B address.
- re_b  in  1  port B read enable (registered mode only).
- dpo  out  DATA_WIDTH  port B read data.

## Operation
- Clear FSM states: CLEAR, IDLE. While RST is low: state = CLEAR, pointer = 0, busy = 1, wr_drop = 0, and registered spo/dpo = 0. The array itself is not reset.
- CLEAR: each cycle write INIT_VALUE to mem[pointer], with all lanes enabled, then increment the pointer. After writing address DEPTH-1, go to IDLE and let the pointer wrap to 0.
- IDLE: clr_req = 1 moves the FSM to CLEAR on the next edge with the pointer at 0. clr_req during CLEAR is ignored; it neither restarts nor extends the pass.
- Writes: in IDLE, we = 1 writes di into every lane of mem[a] whose be bit is 1 at the rising edge. Lanes with be = 0 are unchanged. we with be = 0 is a no-op.
- During busy, user writes are discarded. wr_drop pulses on the cycle after any such we = 1.
- Reads while busy: spo and dpo return INIT_VALUE, in both modes.
- Async mode: spo = mem[a] and dpo = mem[dpra], combinational. A write is visible from the cycle after its edge.
- Registered mode: spo/dpo load on an edge where re_a/re_b = 1 and hold otherwise.
- Port A collision (we with re_a): write-first returns the merged new word; read-first returns the old word.
- Port B with dpra == a during a write always returns the old word.

## Timing
- Clear pass latency: busy is high for exactly DEPTH cycles after RST deasserts, or after the edge that samples clr_req. busy falls on the edge that writes address DEPTH-1.
- First accepted write: the first edge with busy = 0.
- Registered read latency: 1 cycle. Async read latency: 0 cycles.
- Reset asserted mid-pass: the FSM aborts immediately and restarts a full pass from address 0 after release.

## Structure
- Package dist_ram_pkg holds:
  - the clear state enum (CLEAR, IDLE);
  - constants READ_ASYNC = 0 and READ_SYNC = 1;
  - constants RDW_WRITE_FIRST = 0 and RDW_READ_FIRST = 1.
- Sub-module dist_ram_clr_fsm contains the state, pointer, busy and wr_drop logic.
- The top level holds the array, the write mux (user vs. clear) and the read paths.

## Test plan
- Reset release, DEPTH = 64, INIT_VALUE = 16'h0000: busy is high for 64 cycles, then dpo reads 0 at every address.
- In IDLE, write a = 5, di = 16'hABCD, be = 2'b01: mem[5] becomes 16'h00CD. A second write with be = 2'b10 and di = 16'h12FF gives 16'h12CD.
- Registered mode, same-cycle we and re_a at a = 3 (old 16'h1111, new 16'h2222): RDW_MODE = 0 gives spo = 16'h2222 next cycle; RDW_MODE = 1 gives 16'h1111. dpo at dpra = 3 gives 16'h1111.
- clr_req with INIT_VALUE = 16'hFFFF, we = 1 on cycle 10 of the pass: wr_drop pulses once, the location reads FFFF afterwards, and busy is high for 64 cycles.
- RST pulsed low at pointer = 30: outputs return to reset values; after release the pass restarts at 0 and busy is high for 64 cycles.
- Async mode, write a = 63 then read dpra = 63 on the next cycle: dpo shows the new data combinationally. Address wrap is covered by writing 63 and then 0.
